// File: rtl/saes_pkg.sv
// Shared S-AES key-expansion definitions: nibble S-box, nibble helpers, round constants
// and the expansion FSM state type.
package saes_pkg;

    localparam logic [7:0] RCON1_DEF = 8'h80;
    localparam logic [7:0] RCON2_DEF = 8'h30;

    localparam logic [3:0] SBOX [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    typedef enum logic [2:0] {
        StIdle,
        StEmit0,
        StEmit1,
        StEmit2,
        StFin
    } state_e;

    function automatic logic [7:0] sub_nib(input logic [7:0] x);
        return {SBOX[x[7:4]], SBOX[x[3:0]]};
    endfunction

    function automatic logic [7:0] rot_nib(input logic [7:0] x);
        return {x[3:0], x[7:4]};
    endfunction

endpackage

// File: rtl/saes_g_func.sv
// S-AES key-schedule g function: nibble rotate, nibble substitute, then round-constant XOR.
module saes_g_func
    import saes_pkg::*;
(
    input  logic [7:0] i_word,
    input  logic [7:0] i_rcon,
    output logic [7:0] o_word
);

    assign o_word = sub_nib(rot_nib(i_word)) ^ i_rcon;

endmodule

// File: rtl/saes_key_expand.sv
// Sequential S-AES key expansion: streams K0/K1/K2 over valid/ready and latches all three.
module saes_key_expand
    import saes_pkg::*;
#(
    parameter logic [7:0] RCON1 = RCON1_DEF,
    parameter logic [7:0] RCON2 = RCON2_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_key_in,
    output logic        o_busy,
    output logic        o_rk_valid,
    input  logic        i_rk_ready,
    output logic [1:0]  o_rk_idx,
    output logic [15:0] o_round_key,
    output logic [15:0] o_key0,
    output logic [15:0] o_key1,
    output logic [15:0] o_key2,
    output logic        o_keys_valid,
    output logic        o_done
);

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_key0;
    logic [15:0] r_key1;
    logic [15:0] r_key2;
    logic [15:0] r_round_key;
    logic [1:0]  r_rk_idx;
    logic        r_busy;
    logic        r_rk_valid;
    logic        r_keys_valid;
    logic        r_done;

    logic [15:0] w_src;
    logic [7:0]  w_rcon;
    logic [7:0]  w_g_out;
    logic [7:0]  w_hi;
    logic [15:0] w_next_key;
    logic        w_accept;

    // One g instance serves both rounds: K0 feeds K1 in EMIT0, K1 feeds K2 in EMIT1.
    always_comb begin
        w_src  = r_key0;
        w_rcon = RCON1;
        if (r_state == StEmit1) begin
            w_src  = r_key1;
            w_rcon = RCON2;
        end
    end

    saes_g_func u_g_func (
        .i_word (w_src[7:0]),
        .i_rcon (w_rcon),
        .o_word (w_g_out)
    );

    assign w_hi       = w_src[15:8] ^ w_g_out;
    assign w_next_key = {w_hi, w_hi ^ w_src[7:0]};
    assign w_accept   = r_rk_valid & i_rk_ready;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_d = StEmit0;
            StEmit0: if (w_accept) w_state_d = StEmit1;
            StEmit1: if (w_accept) w_state_d = StEmit2;
            StEmit2: if (w_accept) w_state_d = StFin;
            StFin:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_key0       <= '0;
            r_key1       <= '0;
            r_key2       <= '0;
            r_round_key  <= '0;
            r_rk_idx     <= '0;
            r_busy       <= 1'b0;
            r_rk_valid   <= 1'b0;
            r_keys_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_key0       <= i_key_in;
                        r_round_key  <= i_key_in;
                        r_rk_idx     <= 2'd0;
                        r_rk_valid   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_keys_valid <= 1'b0;
                    end
                end
                StEmit0: begin
                    r_key1 <= w_next_key;
                    if (w_accept) begin
                        r_round_key <= w_next_key;
                        r_rk_idx    <= 2'd1;
                    end
                end
                StEmit1: begin
                    r_key2 <= w_next_key;
                    if (w_accept) begin
                        r_round_key <= w_next_key;
                        r_rk_idx    <= 2'd2;
                    end
                end
                StEmit2: begin
                    if (w_accept) begin
                        r_rk_valid <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                StFin: begin
                    r_busy       <= 1'b0;
                    r_keys_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_rk_valid   = r_rk_valid;
    assign o_rk_idx     = r_rk_idx;
    assign o_round_key  = r_round_key;
    assign o_key0       = r_key0;
    assign o_key1       = r_key1;
    assign o_key2       = r_key2;
    assign o_keys_valid = r_keys_valid;
    assign o_done       = r_done;

endmodule

// File: tb/tb_saes_key_expand.sv
// Scoreboard bench for saes_key_expand: stimulus pushes expected round keys, a negedge
// monitor pops and compares them against a word-level S-AES key schedule model.
module tb_saes_key_expand;

    localparam logic [63:0] SBOX_TAB = 64'h94AB_D185_6203_CEF7;
    localparam logic [7:0]  RC1      = 8'h80;
    localparam logic [7:0]  RC2      = 8'h30;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [15:0] key_in   = '0;
    logic        rk_ready = 1'b0;
    logic        busy;
    logic        rk_valid;
    logic [1:0]  rk_idx;
    logic [15:0] round_key;
    logic [15:0] key0;
    logic [15:0] key1;
    logic [15:0] key2;
    logic        keys_valid;
    logic        done;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] key;
    } rk_t;

    typedef struct packed {
        logic [15:0] k0;
        logic [15:0] k1;
        logic [15:0] k2;
    } set_t;

    rk_t         exp_q[$];
    set_t        fin_q[$];
    set_t        cur_set;
    int          n_vec       = 0;
    int          n_err       = 0;
    int          cyc         = 0;
    int          start_cyc   = 0;
    int          lat_exp     = 0;
    bit          chk_latch   = 1'b0;
    bit          ready_rand  = 1'b0;
    int          stall_budget = 0;
    int          stalls_done = 0;
    bit          end_req     = 1'b0;
    bit          end_seen    = 1'b0;

    saes_key_expand u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_key_in     (key_in),
        .o_busy       (busy),
        .o_rk_valid   (rk_valid),
        .i_rk_ready   (rk_ready),
        .o_rk_idx     (rk_idx),
        .o_round_key  (round_key),
        .o_key0       (key0),
        .o_key1       (key1),
        .o_key2       (key2),
        .o_keys_valid (keys_valid),
        .o_done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sb4(input logic [3:0] n);
        int i;
        i = int'(n);
        return SBOX_TAB[63 - 4 * i -: 4];
    endfunction

    // Nibble rotate then substitute, written as substitution of the swapped nibbles.
    function automatic logic [7:0] g8(input logic [7:0] x);
        return {sb4(x[3:0]), sb4(x[7:4])};
    endfunction

    function automatic set_t expand(input logic [15:0] k);
        logic [7:0] w [6];
        logic [7:0] rc [3];
        rc[0] = 8'h00;
        rc[1] = RC1;
        rc[2] = RC2;
        w[0] = k[15:8];
        w[1] = k[7:0];
        for (int r = 1; r <= 2; r++) begin
            w[2*r]   = w[2*r-2] ^ rc[r] ^ g8(w[2*r-1]);
            w[2*r+1] = w[2*r] ^ w[2*r-1];
        end
        return '{k0: {w[0], w[1]}, k1: {w[2], w[3]}, k2: {w[4], w[5]}};
    endfunction

    // Consumer: optional forced stalls while round key 1 is presented, else 1 or random.
    always @(posedge clk) begin
        #1;
        if (stalls_done < stall_budget && rk_valid && rk_idx == 2'd1) begin
            rk_ready    = 1'b0;
            stalls_done = stalls_done + 1;
        end else if (ready_rand) begin
            rk_ready = ($urandom_range(3) != 0);
        end else begin
            rk_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            fin_q.delete();
            chk_latch = 1'b0;
            n_vec++;
            if ({busy, rk_valid, rk_idx, round_key, key0, key1, key2, keys_valid, done} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: busy=%b vld=%b idx=%0d rk=%h k=%h/%h/%h kv=%b done=%b, required all 0",
                         busy, rk_valid, rk_idx, round_key, key0, key1, key2, keys_valid, done);
            end
        end else begin
            if (rk_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rk_unexpected: idx=%0d key=%h, required no round key", rk_idx, round_key);
                end else begin
                    if (rk_idx !== exp_q[0].idx || round_key !== exp_q[0].key || busy !== 1'b1 ||
                        keys_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL rk_stream: idx=%0d key=%h busy=%b kv=%b, required idx=%0d key=%h busy=1 kv=0",
                                 rk_idx, round_key, busy, keys_valid, exp_q[0].idx, exp_q[0].key);
                    end
                    if (rk_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                n_vec++;
                if (fin_q.size() == 0 || exp_q.size() != 0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL done_unexpected: done=1 pending_keys=%0d pending_sets=%0d busy=%b, required 0/1/1",
                             exp_q.size(), fin_q.size(), busy);
                end else begin
                    cur_set   = fin_q.pop_front();
                    chk_latch = 1'b1;
                end
                if (lat_exp != 0) begin
                    n_vec++;
                    if (cyc - start_cyc != lat_exp) begin
                        n_err++;
                        $display("FAIL done_latency: got %0d cycles, required %0d", cyc - start_cyc, lat_exp);
                    end
                end
            end else if (chk_latch) begin
                chk_latch = 1'b0;
                n_vec++;
                if (keys_valid !== 1'b1 || busy !== 1'b0 || key0 !== cur_set.k0 ||
                    key1 !== cur_set.k1 || key2 !== cur_set.k2) begin
                    n_err++;
                    $display("FAIL latched_keys: kv=%b busy=%b k=%h/%h/%h, required kv=1 busy=0 k=%h/%h/%h",
                             keys_valid, busy, key0, key1, key2, cur_set.k0, cur_set.k1, cur_set.k2);
                end
            end
        end
        if (end_req && !end_seen) begin
            end_seen = 1'b1;
            n_vec++;
            if (exp_q.size() != 0 || fin_q.size() != 0) begin
                n_err++;
                $display("FAIL drain: keys left=%0d sets left=%0d, required 0/0", exp_q.size(), fin_q.size());
            end
        end
    end

    // Returns at a negedge of an idle cycle; optionally pulses stray starts while busy.
    task automatic wait_idle(input bit spur);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) return;
            if (spur && $urandom_range(1) == 0) begin
                start  = 1'b1;
                key_in = 16'($urandom);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        $display("FAIL idle_timeout: busy stuck high, required idle within 300 cycles");
        $fatal(1);
    endtask

    task automatic issue(input logic [15:0] k, input set_t e);
        start     = 1'b1;
        key_in    = k;
        start_cyc = cyc;
        exp_q.push_back(rk_t'{idx: 2'd0, key: e.k0});
        exp_q.push_back(rk_t'{idx: 2'd1, key: e.k1});
        exp_q.push_back(rk_t'{idx: 2'd2, key: e.k2});
        fin_q.push_back(e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = 16'($urandom);
    endtask

    initial begin
        logic [15:0] k;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        lat_exp = 4;
        wait_idle(1'b0);
        issue(16'hA73B, '{k0: 16'hA73B, k1: 16'h1C27, k2: 16'h7651});
        wait_idle(1'b0);
        issue(16'h0000, '{k0: 16'h0000, k1: 16'h1919, k2: 16'h0D14});
        wait_idle(1'b0);
        lat_exp      = 7;
        stall_budget = stalls_done + 3;
        issue(16'hA73B, '{k0: 16'hA73B, k1: 16'h1C27, k2: 16'h7651});
        wait_idle(1'b0);
        lat_exp = 0;
        issue(16'h5AC3, expand(16'h5AC3));
        wait_idle(1'b1);

        issue(16'hBEEF, expand(16'hBEEF));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rk_valid && rk_idx == 2'd1) break;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        wait_idle(1'b0);
        k = 16'($urandom);
        issue(k, expand(k));

        ready_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wait_idle($urandom_range(1) == 1);
            k = 16'($urandom);
            issue(k, expand(k));
        end
        wait_idle(1'b0);
        repeat (2) @(negedge clk);
        end_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200000 time units");
        $fatal(1);
    end

endmodule
